// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch front-panel controller.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } sw_state_e;

    localparam int unsigned DATA_W_DEFAULT = 20;
    localparam logic [5:0]  POINT_MASK     = 6'b000_100;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Counter/display side of the stopwatch controller: live count in,
// counter control and seven-segment driver values out.
interface stopwatch_ctrl_if
    import stopwatch_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT
);
    logic [DATA_W-1:0] live_data;
    logic              cnt_en;
    logic              cnt_clr;
    logic [DATA_W-1:0] disp_data;
    logic [1:0]        state;
    logic              seg_en;
    logic [5:0]        point;
    logic              sign;

    modport master (
        input  live_data,
        output cnt_en, cnt_clr, disp_data, state, seg_en, point, sign
    );

    modport slave (
        output live_data,
        input  cnt_en, cnt_clr, disp_data, state, seg_en, point, sign
    );
endinterface

// File: rtl/stopwatch_ctrl_key_filter.sv
// Push-button conditioner: 2-FF synchronizer, stable-level debounce and a
// one-cycle pulse on each accepted press (1->0). Releases give no pulse.
module key_filter #(
    parameter logic [19:0] DEBOUNCE_CNT = 20'd999_999
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_n,
    output logic press
);
    logic        sync1_q;
    logic        sync2_q;
    logic        stable_q;
    logic        stable_prev_q;
    logic        press_q;
    logic [19:0] cnt_q;

    // Bring the asynchronous key level into the sys_clk domain.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CNT+1 cycles.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            stable_q <= 1'b1;
            cnt_q    <= '0;
        end else if (sync2_q == stable_q) begin
            cnt_q <= '0;
        end else if (cnt_q == DEBOUNCE_CNT) begin
            stable_q <= sync2_q;
            cnt_q    <= '0;
        end else begin
            cnt_q <= cnt_q + 20'd1;
        end
    end

    // Registered falling-edge detect on the debounced level.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            stable_prev_q <= 1'b1;
            press_q       <= 1'b0;
        end else begin
            stable_prev_q <= stable_q;
            press_q       <= stable_prev_q & ~stable_q;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch front-panel controller: three debounced keys drive a
// run/pause/lap FSM that controls the 0.1 s counter and picks the
// value (live or frozen lap) shown on the seven-segment display.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter logic [19:0] DEBOUNCE_CNT = 20'd999_999,
    parameter int unsigned DATA_W       = DATA_W_DEFAULT
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             key_start_n,
    input  logic             key_lap_n,
    input  logic             key_clr_n,
    stopwatch_ctrl_if.master dp
);
    logic start_p;
    logic lap_p;
    logic clr_p;

    sw_state_e         state_q;
    logic [DATA_W-1:0] lap_q;
    logic [DATA_W-1:0] disp_q;
    logic              cnt_en_q;
    logic              cnt_clr_q;
    logic              seg_en_q;
    logic [5:0]        point_q;

    key_filter #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_key_start (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key_n     (key_start_n),
        .press     (start_p)
    );

    key_filter #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_key_lap (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key_n     (key_lap_n),
        .press     (lap_p)
    );

    key_filter #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_key_clr (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key_n     (key_clr_n),
        .press     (clr_p)
    );

    // Run/pause/lap FSM with lap capture and registered outputs.
    // cnt_en is set on every edge that enters RUN/LAP and cleared on every
    // edge that leaves them, so it always equals "state is RUN or LAP".
    // Clear only acts in PAUSE, so clr > start > lap reduces to clr > start
    // there and start > lap in RUN/LAP.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= ST_IDLE;
            lap_q     <= '0;
            disp_q    <= '0;
            cnt_en_q  <= 1'b0;
            cnt_clr_q <= 1'b0;
            seg_en_q  <= 1'b0;
            point_q   <= '0;
        end else begin
            disp_q    <= (state_q == ST_LAP) ? lap_q : dp.live_data;
            seg_en_q  <= 1'b1;
            point_q   <= POINT_MASK;
            cnt_clr_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_p) begin
                        state_q  <= ST_RUN;
                        cnt_en_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (start_p) begin
                        state_q  <= ST_PAUSE;
                        cnt_en_q <= 1'b0;
                    end else if (lap_p) begin
                        state_q <= ST_LAP;
                        lap_q   <= dp.live_data;
                    end
                end
                ST_LAP: begin
                    if (start_p) begin
                        state_q  <= ST_PAUSE;
                        cnt_en_q <= 1'b0;
                    end else if (lap_p) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_PAUSE: begin
                    if (clr_p) begin
                        state_q   <= ST_IDLE;
                        cnt_clr_q <= 1'b1;
                    end else if (start_p) begin
                        state_q  <= ST_RUN;
                        cnt_en_q <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    cnt_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign dp.cnt_en    = cnt_en_q;
    assign dp.cnt_clr   = cnt_clr_q;
    assign dp.disp_data = disp_q;
    assign dp.state     = state_q;
    assign dp.seg_en    = seg_en_q;
    assign dp.point     = point_q;
    assign dp.sign      = 1'b0;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with a short debounce window.
module tb_stopwatch_ctrl;

    localparam int unsigned D = 4;
    localparam int unsigned W = 20;

    logic sys_clk     = 1'b0;
    logic sys_rst_n   = 1'b0;
    logic key_start_n = 1'b1;
    logic key_lap_n   = 1'b1;
    logic key_clr_n   = 1'b1;

    int n_checks = 0;
    int n_errors = 0;
    int clr_seen = 0;

    stopwatch_ctrl_if #(.DATA_W(W)) dp_if ();

    stopwatch_ctrl #(.DEBOUNCE_CNT(20'd4), .DATA_W(W)) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .key_start_n (key_start_n),
        .key_lap_n   (key_lap_n),
        .key_clr_n   (key_clr_n),
        .dp          (dp_if)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference model: states 0 idle, 1 run, 2 pause, 3 lap.
    int          m_state;
    logic [19:0] m_lap;
    logic [19:0] m_disp;
    bit          m_en;
    bit          m_clr;
    bit          m_seg;
    logic [5:0]  m_point;
    // Per key (0 start, 1 lap, 2 clear): raw history, accepted level,
    // length of the current disagreement run, press delay line.
    bit r1[3];
    bit r2[3];
    bit stab[3];
    int run[3];
    bit p0[3];
    bit p1[3];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit raw_key(input int k);
        case (k)
            0:       return key_start_n;
            1:       return key_lap_n;
            default: return key_clr_n;
        endcase
    endfunction

    task automatic model_reset();
        m_state = 0; m_lap = '0; m_disp = '0;
        m_en = 0; m_clr = 0; m_seg = 0; m_point = '0;
        for (int k = 0; k < 3; k++) begin
            r1[k] = 1; r2[k] = 1; stab[k] = 1; run[k] = 0; p0[k] = 0; p1[k] = 0;
        end
    endtask

    task automatic model_edge();
        bit fire[3];
        int nxt;
        // A key level is accepted after the synchronized level (raw two
        // edges back) has disagreed for D+1 consecutive edges; the press
        // acts on the FSM two edges after acceptance.
        for (int k = 0; k < 3; k++) begin
            bit d;
            fire[k] = p1[k];
            p1[k] = p0[k];
            p0[k] = 0;
            d = r2[k];
            if (d != stab[k]) run[k]++; else run[k] = 0;
            if (run[k] == int'(D) + 1) begin
                stab[k] = d;
                run[k] = 0;
                if (d == 1'b0) p0[k] = 1;
            end
            r2[k] = r1[k];
            r1[k] = raw_key(k);
        end
        m_disp = (m_state == 3) ? m_lap : dp_if.live_data;
        nxt = m_state;
        m_clr = 0;
        case (m_state)
            0: if (fire[0]) nxt = 1;
            1: if (fire[0]) nxt = 2;
               else if (fire[1]) begin nxt = 3; m_lap = dp_if.live_data; end
            3: if (fire[0]) nxt = 2;
               else if (fire[1]) nxt = 1;
            default: if (fire[2]) begin nxt = 0; m_clr = 1; end
                     else if (fire[0]) nxt = 1;
        endcase
        m_state = nxt;
        m_en = (nxt == 1) || (nxt == 3);
        m_seg = 1;
        m_point = 6'b000_100;
    endtask

    task automatic compare_all();
        check_eq("state",     32'(dp_if.state),     32'(m_state));
        check_eq("cnt_en",    32'(dp_if.cnt_en),    32'(m_en));
        check_eq("cnt_clr",   32'(dp_if.cnt_clr),   32'(m_clr));
        check_eq("disp_data", 32'(dp_if.disp_data), 32'(m_disp));
        check_eq("seg_en",    32'(dp_if.seg_en),    32'(m_seg));
        check_eq("point",     32'(dp_if.point),     32'(m_point));
        check_eq("sign",      32'(dp_if.sign),      32'd0);
        if (dp_if.cnt_clr === 1'b1 && dp_if.cnt_en === 1'b1)
            check_eq("clr_while_en", 32'd1, 32'd0);
    endtask

    task automatic cycle();
        @(posedge sys_clk);
        if (sys_rst_n) model_edge(); else model_reset();
        @(negedge sys_clk);
        compare_all();
        if (dp_if.cnt_clr === 1'b1) clr_seen++;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic set_keys(input bit [2:0] low_mask);
        key_start_n = ~low_mask[0];
        key_lap_n   = ~low_mask[1];
        key_clr_n   = ~low_mask[2];
    endtask

    task automatic press_keys(input bit [2:0] mask, input int low_len, input int high_len);
        set_keys(mask);
        cycles(low_len);
        set_keys(3'b000);
        cycles(high_len);
    endtask

    // Reset asserted between clock edges; outputs must clear at once.
    task automatic async_reset(input int hold);
        #2;
        sys_rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        check_eq("rst_disp_now", 32'(dp_if.disp_data), 32'd0);
        @(negedge sys_clk);
        cycles(hold);
        sys_rst_n = 1'b1;
    endtask

    initial begin
        int rem[3];
        bit lvl[3];
        model_reset();
        dp_if.live_data = '0;
        cycles(3);
        sys_rst_n = 1'b1;
        cycles(2);

        // Short glitch and bounces: no press accepted.
        set_keys(3'b001); cycles(3);
        set_keys(3'b000); cycles(2);
        for (int b = 0; b < 4; b++) begin
            set_keys(3'b001); cycles(2);
            set_keys(3'b000); cycles(2);
        end
        cycles(12);
        check_eq("glitch_idle", 32'(dp_if.state), 32'd0);

        // Long start press with ramping live data.
        set_keys(3'b001);
        for (int i = 0; i < 20; i++) begin dp_if.live_data = 20'(i * 3); cycle(); end
        set_keys(3'b000); cycles(10);
        check_eq("start_run", 32'(dp_if.state), 32'd1);

        // Lap freeze and release.
        dp_if.live_data = 20'd1234;
        press_keys(3'b010, 10, 6);
        check_eq("lap_state", 32'(dp_if.state), 32'd3);
        for (int v = 1235; v <= 1300; v++) begin dp_if.live_data = 20'(v); cycle(); end
        check_eq("lap_hold", 32'(dp_if.disp_data), 32'd1234);
        press_keys(3'b010, 10, 8);
        check_eq("lap_release", 32'(dp_if.state), 32'd1);
        dp_if.live_data = 20'd4321; cycles(2);
        check_eq("track_live", 32'(dp_if.disp_data), 32'd4321);

        // Pause, clear, clear-in-idle.
        press_keys(3'b001, 10, 8);
        check_eq("pause", 32'(dp_if.state), 32'd2);
        clr_seen = 0;
        press_keys(3'b100, 10, 8);
        check_eq("clr_idle", 32'(dp_if.state), 32'd0);
        check_eq("clr_pulses", 32'(clr_seen), 32'd1);
        clr_seen = 0;
        press_keys(3'b100, 10, 8);
        check_eq("clr_in_idle", 32'(clr_seen), 32'd0);

        // Coincident start + clear in RUN, then in PAUSE.
        press_keys(3'b001, 10, 8);
        clr_seen = 0;
        press_keys(3'b101, 10, 8);
        check_eq("coinc_run", 32'(dp_if.state), 32'd2);
        check_eq("coinc_run_clr", 32'(clr_seen), 32'd0);
        press_keys(3'b101, 10, 8);
        check_eq("coinc_pause", 32'(dp_if.state), 32'd0);
        check_eq("coinc_pause_clr", 32'(clr_seen), 32'd1);

        // Reset in the middle of LAP.
        press_keys(3'b001, 10, 8);
        dp_if.live_data = 20'd555;
        press_keys(3'b010, 10, 8);
        check_eq("lap555", 32'(dp_if.disp_data), 32'd555);
        dp_if.live_data = 20'd777;
        async_reset(2);
        cycles(3);
        check_eq("post_rst_live", 32'(dp_if.disp_data), 32'd777);
        check_eq("post_rst_state", 32'(dp_if.state), 32'd0);

        // Randomized key activity and data.
        for (int k = 0; k < 3; k++) begin rem[k] = 0; lvl[k] = 1; end
        for (int i = 0; i < 4000; i++) begin
            for (int k = 0; k < 3; k++) begin
                if (rem[k] == 0) begin
                    lvl[k] = 1'($urandom_range(0, 1));
                    rem[k] = int'($urandom_range(1, 14));
                end
                rem[k]--;
            end
            key_start_n = lvl[0];
            key_lap_n   = lvl[1];
            key_clr_n   = lvl[2];
            if ($urandom_range(0, 1) == 0) dp_if.live_data = dp_if.live_data + 20'd1;
            else dp_if.live_data = 20'($urandom);
            if ($urandom_range(0, 499) == 0) async_reset(int'($urandom_range(0, 3)));
            else cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Front-panel controller for the stopwatch datapath. It debounces three push-buttons (start/stop, lap, clear) and runs a 4-state run/pause/lap FSM. The FSM drives the count-enable and synchronous-clear inputs of the 0.1 s counter. It also selects the value sent to the 6-digit seven-segment driver: either the live count or a frozen lap value.

Parameters:
DEBOUNCE_CNT, 20'd999_999, stable-sample cycles required before a key change is accepted (20 ms at 50 MHz)
DATA_W, 20, width of the count and display data

Ports:
sys_clk  in  1  system clock, 50 MHz
sys_rst_n  in  1  reset
key_start_n  in  1  raw start/stop button, active-low, asynchronous
key_lap_n  in  1  raw lap button, active-low, asynchronous
key_clr_n  in  1  raw clear button, active-low, asynchronous
live_data  in  DATA_W  current counter value (tenths of a second)
cnt_en  out  1  counter advance enable
cnt_clr  out  1  one-cycle synchronous clear to the counter
disp_data  out  DATA_W  value for the segment driver
state  out  2  FSM state for status LEDs
seg_en  out  1  segment driver enable
point  out  6  decimal-point mask
sign  out  1  sign digit

Behaviour:
- Reset: sys_rst_n is asynchronous, active-low; the clock is sys_clk. While in reset, all outputs are 0, the FSM is IDLE, lap_reg is 0, and filter stable levels are 1.
- Key filtering:
  - Each key passes through a 2-FF synchronizer.
  - A counter increments each cycle while the synced level differs from the stable level, and clears to 0 whenever they are equal.
  - When the counter equals DEBOUNCE_CNT and the levels still differ: stable takes the synced level and the counter clears.
  - press = registered (stable_prev & ~stable): a one-cycle pulse on each accepted 1->0 change. Releases produce no pulse.
  - A glitch shorter than DEBOUNCE_CNT+1 synced cycles produces no pulse.
- Event priority, when pulses coincide: clr > start > lap. Only the highest-priority pulse acts that cycle; the others are dropped.
- FSM states: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, LAP=2'd3. Transitions take effect on the edge after the pulse.
  - IDLE: start -> RUN; lap and clr are ignored.
  - RUN: start -> PAUSE; lap -> LAP, and lap_reg <= live_data on the same edge; clr is ignored.
  - LAP: start -> PAUSE; lap -> RUN (releases the freeze); clr is ignored.
  - PAUSE: start -> RUN; clr -> IDLE, and cnt_clr=1 for exactly that one cycle; lap is ignored.
- cnt_en: registered; 1 exactly when the next state is RUN or LAP, so it tracks state with no extra lag.
- cnt_clr: registered. It is never asserted in RUN or LAP, so it is never asserted while cnt_en=1.
- disp_data: registered one cycle after selection.
  - In LAP, it shows lap_reg.
  - In all other states, it shows live_data, so there is 1 cycle of latency from live_data.
  - On entry to LAP, disp_data shows the captured value on the following cycle.
- seg_en: 0 in reset, 1 from the first clock after reset release.
- point: constant 6'b000_100. sign: constant 0.
- Counter wrap (999_999 -> 0) is the datapath's concern. A wrap during LAP does not change lap_reg.
- Reset mid-debounce or mid-state: everything returns to reset values and any pending press is lost.
- A key held low produces exactly one pulse; the next pulse requires a release followed by a new press.

Decomposition:
- Package stopwatch_pkg:
  - FSM state encodings ST_IDLE, ST_RUN, ST_PAUSE, ST_LAP.
  - DATA_W default.
  - POINT_MASK = 6'b000_100.
- Sub-module key_filter: parameter DEBOUNCE_CNT; ports sys_clk, sys_rst_n, key_n, press. Instantiated 3 times.
- The FSM, lap register and output registers stay in stopwatch_ctrl.

Test Plan (DEBOUNCE_CNT=4):
1. Reset, then key_start_n low for 20 cycles -> one press pulse; state 0->1; cnt_en rises the same cycle; disp_data follows live_data with 1-cycle lag; seg_en=1, point=6'b000_100, sign=0.
2. key_start_n glitches low for 3 cycles, then bounces 4 times -> no pulse; state stays IDLE; cnt_en=0.
3. In RUN with live_data=20'd1234, press lap -> state=3, disp_data=1234 held while live_data ramps to 1300; press lap again -> state=1 and disp_data tracks live_data.
4. In RUN, press start -> state=2, cnt_en=0; press clr -> cnt_clr high exactly 1 cycle, state=0; then press clr in IDLE -> no cnt_clr.
5. In RUN, force start and clr pulses on the same cycle -> clr is ignored in RUN and start wins: state=2 and cnt_clr stays 0. In PAUSE, force start and clr on the same cycle -> state=0 and cnt_clr pulses.
6. Assert sys_rst_n low asynchronously mid-LAP with lap_reg=20'd555 -> all outputs 0 immediately, state=0; after release, disp_data=live_data and the old lap value is gone.
